// File: rtl/col_buf_pkg.sv
// col_buf_pkg: shared widths, types and ring-pointer helpers for the column buffer ring
package col_buf_pkg;
  localparam int DATA_W = 512;
  localparam int SEG_W = 64;
  localparam int DEPTH = 512;
  localparam int NUM_SEG = DATA_W / SEG_W;
  localparam int ADDR_W = $clog2(DEPTH);
  function automatic int buf_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int BUF_W = buf_w(8);
  typedef logic [BUF_W-1:0] buf_idx_t;
  typedef logic [ADDR_W-1:0] col_addr_t;
  typedef logic [SEG_W-1:0] seg_t;
  function automatic int ring_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/col_buf_if.sv
// col_buf_if: loader/reader bus of the column buffer ring; `define COL_BUF_PERF_CNT_EN adds stall counters
interface col_buf_if import col_buf_pkg::*; #(
  parameter int NUM_BUF = 2
);
  localparam int BW = buf_w(NUM_BUF);
  logic wr_en;
  logic [NUM_SEG-1:0] wr_seg_en;
  col_addr_t wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic wr_commit;
  logic wr_ready;
  logic [BW-1:0] wr_buf_idx;
  logic rd_en;
  col_addr_t rd_addr;
  logic rd_release;
  logic rd_ready;
  logic [BW-1:0] rd_buf_idx;
  logic rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic err_ovf;
  logic err_unf;
`ifdef COL_BUF_PERF_CNT_EN
  logic [31:0] perf_wr_stall;
  logic [31:0] perf_rd_stall;
`endif
  modport master (
    output wr_en, wr_seg_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    input wr_ready, wr_buf_idx, rd_ready, rd_buf_idx, rd_valid, rd_data, err_ovf, err_unf
`ifdef COL_BUF_PERF_CNT_EN
    , input perf_wr_stall, perf_rd_stall
`endif
  );
  modport slave (
    input wr_en, wr_seg_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    output wr_ready, wr_buf_idx, rd_ready, rd_buf_idx, rd_valid, rd_data, err_ovf, err_unf
`ifdef COL_BUF_PERF_CNT_EN
    , output perf_wr_stall, perf_rd_stall
`endif
  );
endinterface

// File: rtl/col_buf_bank.sv
// col_buf_bank: one B-matrix buffer as NUM_SEG simple dual-port block RAMs with RD_LAT read latency
module col_buf_bank import col_buf_pkg::*; #(
  parameter int RD_LAT = 3
) (
  input  logic               clk,
  input  logic               ena,
  input  logic [NUM_SEG-1:0] wea,
  input  col_addr_t          addra,
  input  logic [DATA_W-1:0]  dina,
  input  logic               enb,
  input  col_addr_t          addrb,
  output logic [DATA_W-1:0]  doutb
);
  for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
    seg_t mem [DEPTH];
    seg_t q [RD_LAT];
    // write port A; port B latches pre-write contents, then shifts through the output pipeline
    always_ff @(posedge clk) begin
      if (ena && wea[s]) mem[addra] <= dina[s*SEG_W +: SEG_W];
      if (enb) q[0] <= mem[addrb];
      for (int i = 1; i < RD_LAT; i++) q[i] <= q[i-1];
    end
    assign doutb[s*SEG_W +: SEG_W] = q[RD_LAT-1];
  end
endmodule

// File: rtl/col_buf_ring.sv
// col_buf_ring: N-buffer ring of transposed B columns with commit/release handshake; macro COL_BUF_PERF_CNT_EN adds stall counters
module col_buf_ring import col_buf_pkg::*; #(
  parameter int NUM_BUF = 2,
  parameter int RD_LAT = 3
) (
  input logic      clk,
  input logic      rst,
  col_buf_if.slave bus
);
  localparam int BW = buf_w(NUM_BUF);
  logic [BW-1:0] wp, rp;
  logic [3:0] full_cnt;
  logic wr_ready, rd_ready, wr_acc, rd_acc, cm_acc, rl_acc, rd_valid, err_ovf, err_unf;
  logic [RD_LAT-1:0] vld_p;
  logic [BW-1:0] sel_p [RD_LAT];
  logic [DATA_W-1:0] bank_q [NUM_BUF];
  assign wr_ready = full_cnt < 4'(NUM_BUF);
  assign rd_ready = full_cnt != '0;
  assign wr_acc = bus.wr_en && wr_ready;
  assign rd_acc = bus.rd_en && rd_ready;
  assign cm_acc = bus.wr_commit && wr_ready;
  assign rl_acc = bus.rd_release && rd_ready;
  assign rd_valid = vld_p[RD_LAT-1];
  // ring pointers, occupancy and sticky protocol errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      full_cnt <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (cm_acc) wp <= BW'(ring_inc(int'(wp), NUM_BUF));
      if (rl_acc) rp <= BW'(ring_inc(int'(rp), NUM_BUF));
      full_cnt <= full_cnt + 4'(cm_acc) - 4'(rl_acc);
      err_ovf <= err_ovf | (bus.wr_commit && !wr_ready);
      err_unf <= err_unf | ((bus.rd_release || bus.rd_en) && !rd_ready);
    end
  end
  // valid and source-buffer index travel with the read so a release mid-flight cannot redirect it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < RD_LAT; i++) sel_p[i] <= '0;
    end else begin
      vld_p[0] <= rd_acc;
      sel_p[0] <= rp;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        sel_p[i] <= sel_p[i-1];
      end
    end
  end
  for (genvar i = 0; i < NUM_BUF; i++) begin : g_bank
    col_buf_bank #(.RD_LAT(RD_LAT)) u_bank (
      .clk   (clk),
      .ena   (wr_acc && wp == BW'(i)),
      .wea   (bus.wr_seg_en),
      .addra (bus.wr_addr),
      .dina  (bus.wr_data),
      .enb   (rd_acc && rp == BW'(i)),
      .addrb (bus.rd_addr),
      .doutb (bank_q[i])
    );
  end
  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;
  assign bus.wr_buf_idx = wp;
  assign bus.rd_buf_idx = rp;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data = rd_valid ? bank_q[sel_p[RD_LAT-1]] : '0;
  assign bus.err_ovf = err_ovf;
  assign bus.err_unf = err_unf;
`ifdef COL_BUF_PERF_CNT_EN
  logic [31:0] perf_wr, perf_rd;
  // saturating counts of stalled write and read requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_wr <= '0;
      perf_rd <= '0;
    end else begin
      if (bus.wr_en && !wr_ready && perf_wr != '1) perf_wr <= perf_wr + 32'd1;
      if (bus.rd_en && !rd_ready && perf_rd != '1) perf_rd <= perf_rd + 32'd1;
    end
  end
  assign bus.perf_wr_stall = perf_wr;
  assign bus.perf_rd_stall = perf_rd;
`endif
endmodule
